// File: rtl/fetch_pkg.sv
// Fetch-stage payload types.
package fetch_pkg;

  import len5_pkg::XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } prediction_t;

endpackage

// File: rtl/len5_pkg.sv
// Core-wide constants and types shared by the front-end decode blocks.
package len5_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef logic [ILEN-1:0] instr_t;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  // Link registers that mark a call/return, and the zero register
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd1;
  localparam logic [4:0] REG_T0   = 5'd5;

  typedef enum logic [1:0] {
    JUMP_NONE,
    JUMP_JAL,
    JUMP_CALL,
    JUMP_RET
  } jump_type_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: overflow overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  r_stack [DEPTH];
  logic [PTR_W-1:0] r_ptr;  // next free slot; top is one below
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_top_idx;

  assign w_top_idx = r_ptr - PTR_W'(1);
  assign top_o     = r_stack[w_top_idx];
  assign empty_o   = (r_cnt == '0);

  // Stack storage, pointer and count; clear acts before a same-cycle push
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stack[i] <= '0;
      end
    end else if (push_i) begin
      r_stack[r_ptr] <= data_i;
      r_ptr          <= r_ptr + PTR_W'(1);
      if (clear_i) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != CNT_W'(DEPTH)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (pop_i && !empty_o) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/early_jump_ras_dec.sv
// Early jump decoder: redirects fetch for JAL and, via the RAS, for returns.
module early_jump_ras_dec
  import len5_pkg::*;
  import fetch_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RAS_EN    = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            ras_clear_i,
  input  instr_t          instr_i,
  input  logic            instr_valid_i,
  input  logic            issue_ready_i,
  input  prediction_t     mem_if_pred_i,
  input  logic [XLEN-1:0] early_jump_target_i,
  output prediction_t     issue_pred_o,
  output logic            early_jump_valid_o,
  output logic            mem_flush_o,
  output logic [XLEN-1:0] early_jump_base_o,
  output logic [XLEN-1:0] early_jump_offs_o
);

  typedef enum logic [1:0] {
    S_RESET,
    S_IDLE,
    S_WAIT_ISSUE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  jump_type_t      w_jtype;
  logic            w_is_jump;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [2:0]      w_funct3;
  logic [11:0]     w_imm12;
  logic [XLEN-1:0] w_jimm;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;

  assign w_opcode = instr_i[6:0];
  assign w_rd     = instr_i[11:7];
  assign w_funct3 = instr_i[14:12];
  assign w_rs1    = instr_i[19:15];
  assign w_imm12  = instr_i[31:20];
  assign w_jimm   = {{(XLEN - 21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};

  // Jump classification; a return is only predicted when the RAS holds an entry
  always_comb begin
    w_jtype = JUMP_NONE;
    if (w_opcode == OPC_JAL) begin
      w_jtype = ((w_rd == REG_RA) || (w_rd == REG_T0)) ? JUMP_CALL : JUMP_JAL;
    end else if ((w_opcode == OPC_JALR) && (w_funct3 == 3'b000) &&
                 (w_rd == REG_ZERO) && ((w_rs1 == REG_RA) || (w_rs1 == REG_T0)) &&
                 (w_imm12 == 12'd0) && (RAS_EN != 0) && !w_ras_empty) begin
      w_jtype = JUMP_RET;
    end
  end

  assign w_is_jump = (w_jtype != JUMP_NONE);

  // Target operands handed to the PC generator adder
  always_comb begin
    early_jump_base_o = mem_if_pred_i.pc;
    early_jump_offs_o = w_jimm;
    if (w_jtype == JUMP_RET) begin
      early_jump_base_o = '0;
      early_jump_offs_o = w_ras_top;
    end
  end

  // Prediction forwarded to issue
  always_comb begin
    issue_pred_o.pc     = mem_if_pred_i.pc;
    issue_pred_o.target = w_is_jump ? early_jump_target_i : mem_if_pred_i.target;
    issue_pred_o.taken  = w_is_jump | mem_if_pred_i.taken;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and redirect handshake; flush overrides any transition
  always_comb begin
    w_next_state       = r_state;
    early_jump_valid_o = 1'b0;
    mem_flush_o        = 1'b0;
    case (r_state)
      S_RESET: w_next_state = S_IDLE;
      S_IDLE: begin
        early_jump_valid_o = instr_valid_i & w_is_jump;
        mem_flush_o        = early_jump_valid_o & issue_ready_i;
        if (early_jump_valid_o && !issue_ready_i) begin
          w_next_state = S_WAIT_ISSUE;
        end
      end
      S_WAIT_ISSUE: begin
        early_jump_valid_o = 1'b1;
        mem_flush_o        = issue_ready_i;
        if (issue_ready_i) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (flush_i) begin
      w_next_state = S_IDLE;
    end
  end

  assign w_accept = mem_flush_o & ~flush_i;
  assign w_push   = w_accept & (w_jtype == JUMP_CALL);
  assign w_pop    = w_accept & (w_jtype == JUMP_RET);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (ras_clear_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (mem_if_pred_i.pc + XLEN'(4)),
    .top_o   (w_ras_top),
    .empty_o (w_ras_empty)
  );

endmodule
